// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the EX stage and the iterative multiply/divide unit.
// The master drives the request side and the slave returns stall, busy and the result.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [4:0]      rd_in;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, op, srca, srcb, rd_in,
        input  stall, busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, op, srca, srcb, rd_in,
        output stall, busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit: sign-magnitude radix-2 iteration (shift-add / restoring divide),
// sign fix-up, then a one-cycle done pulse with the destination register.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;   // multiplicand or divisor magnitude
    logic [XLEN-1:0]   hi_q;     // product high / partial remainder
    logic [XLEN-1:0]   lo_q;     // multiplier-then-product low / dividend-then-quotient

    logic              accept, div_zero, div_ovf, special;
    logic              sign_a, sign_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [XLEN:0]     add_sum, rem_sh;
    logic [XLEN+1:0]   diff;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    // Request decode: op[2] selects divide, op[1] remainder, op[0] unsigned divide.
    always_comb begin
        accept   = bus.start && !bus.kill;
        div_zero = bus.op[2] && (bus.srcb == '0);
        div_ovf  = bus.op[2] && !bus.op[0] && (bus.srca == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.srcb == '1);
        special  = div_zero || div_ovf;
        if (bus.op[2]) begin
            sign_a = !bus.op[0];
            sign_b = !bus.op[0];
        end else begin
            sign_a = (bus.op[1:0] == 2'b01) || (bus.op[1:0] == 2'b10);
            sign_b = (bus.op[1:0] == 2'b01);
        end
        neg_a = sign_a && bus.srca[XLEN-1];
        neg_b = sign_b && bus.srcb[XLEN-1];
        mag_a = neg_a ? -bus.srca : bus.srca;
        mag_b = neg_b ? -bus.srcb : bus.srcb;
        if (div_zero) special_res = bus.op[1] ? bus.srca : '1;
        else          special_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration step, shared datapath registers for both operation classes.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = {hi_q, lo_q[XLEN-1]};
        diff    = {1'b0, rem_sh} - {2'b00, opnd_q};
        if (op_q[2]) begin
            hi_step = diff[XLEN+1] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], ~diff[XLEN+1]};
        end else begin
            hi_step = add_sum[XLEN:1];
            lo_step = {add_sum[0], lo_q[XLEN-1:1]};
        end
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        if (op_q[2]) begin
            if (op_q[1]) fix_res = neg_q ? -hi_q : hi_q;
            else         fix_res = neg_q ? -lo_q : lo_q;
        end else begin
            fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) state_next = special ? S_DONE : S_CALC;
            S_CALC: if (bus.kill) state_next = S_IDLE;
                    else if (cnt == '1) state_next = S_FIX;
            S_FIX:  state_next = bus.kill ? S_IDLE : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.stall = reset && (((state == S_IDLE) && accept) || (state == S_CALC) || (state == S_FIX));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_next;
            bus.busy <= (state_next == S_CALC) || (state_next == S_FIX);
            bus.done <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            bus.result <= '0;
            bus.rd_out <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    cnt    <= '0;
                    op_q   <= bus.op;
                    rd_q   <= bus.rd_in;
                    hi_q   <= '0;
                    opnd_q <= bus.op[2] ? mag_b : mag_a;
                    lo_q   <= bus.op[2] ? mag_a : mag_b;
                    neg_q  <= (bus.op[2] && bus.op[1]) ? neg_a : (neg_a ^ neg_b);
                    if (special) begin
                        bus.result <= special_res;
                        bus.rd_out <= bus.rd_in;
                    end
                end
                S_CALC: if (!bus.kill) begin
                    cnt  <= cnt + 1'b1;
                    hi_q <= hi_step;
                    lo_q <= lo_step;
                end
                S_FIX: if (!bus.kill) begin
                    bus.result <= fix_res;
                    bus.rd_out <= rd_q;
                end
                default: ;
            endcase
        end
    end
endmodule
